weight_fetch_unit: RTL
======================

# weight_fetch_unit

Producer side of the weight FIFO: on a start command, reads `num_tiles_i` consecutive weight tiles of MUL_SIZE rows each from the synchronous weight memory. It pushes every row, in address order, into the weight FIFO through a valid/ready write port. The FIFO's read side feeds `weight_control_unit`. A 2-entry skid buffer keeps the stream at one row per cycle under backpressure without losing or duplicating rows.

## Interface
- MUL_SIZE, `tpu_package::MUL_SIZE`, systolic array dimension; rows per tile and row width in elements.
- DATA_W, 8, bits per weight element.
- ADDR_W, 16, weight memory row-address width.
- TILE_W, 8, width of the tile count.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low; the synchronous deassert is handled upstream.
- start_i  in  1  one-cycle command pulse; ignored unless idle.
- base_addr_i  in  ADDR_W  row address of tile 0 row 0; sampled with start_i.
- num_tiles_i  in  TILE_W  tile count; sampled with start_i.
- weight_mem_rd_en_o  out  1  memory read strobe.
- weight_mem_addr_o  out  ADDR_W  read address; valid with rd_en.
- weight_mem_data_i  in  MUL_SIZE*DATA_W  read data; valid exactly 1 cycle after rd_en.
- weight_fifo_wr_valid_o  out  1  row available to FIFO.
- weight_fifo_wr_ready_i  in  1  FIFO can accept.
- weight_fifo_wr_data_o  out  MUL_SIZE*DATA_W  row data.
- busy_o  out  1  high from cycle after accepted start until done.
- tile_done_o  out  1  one-cycle pulse after last row of each tile is accepted.
- done_o  out  1  one-cycle pulse when the whole command is complete.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE + start_i: latch base address, tile count, clear row_cntr/tile_cntr/issue address → FETCH. If num_tiles_i == 0 → IDLE directly, done_o pulses next cycle, no reads.
- Credit rule: occ = skid-buffer entries (0..2), infl = reads with data not yet returned (0..1), pop = wr_valid_o & wr_ready_i.
  - rd_en_o = (state == FETCH) & (occ + infl − pop < 2).
  - rd_en_o is combinational on wr_ready_i by design.
- Each issued read increments the issue address, modulo 2^ADDR_W, so wrap-around is silent.
- Last read issued (num_tiles × MUL_SIZE reads total) → DRAIN.
- Returned data is written to the buffer tail. wr_valid_o = occ != 0, and wr_data_o = buffer head, both registered.
- Simultaneous push and pop: occ is unchanged and order is preserved. The buffer never overflows; overflow is an assertion failure.
- Each pop increments row_cntr.
  - row_cntr wraps at MUL_SIZE−1 → tile_cntr++ and tile_done_o pulses next cycle.
  - If that was the final tile: done_o pulses the same cycle as the final tile_done_o, busy_o drops, and the state returns to IDLE.
- start_i while not IDLE is ignored; no state change.
- Reset (any state, mid-transfer included): state IDLE, counters 0, buffer emptied, in-flight data discarded. All outputs 0: rd_en, addr, wr_valid, wr_data, busy, tile_done, done.

## Timing
- Cycle 0: start_i high in IDLE.
- Cycle 1: busy_o=1, rd_en_o=1, addr=base.
- Cycle 2: data returns, rd_en_o=1, addr=base+1.
- Cycle 3: wr_valid_o=1 with row base.
- With wr_ready_i held high, one row per cycle thereafter. Last row N−1 (N = tiles×MUL_SIZE) is valid in cycle N+2, and done_o/busy_o fall in cycle N+3.
- Backpressure: with wr_ready_i low, at most 2 rows are buffered. rd_en_o stays low while occ+infl = 2, and wr_valid_o/wr_data_o are held stable.
- Ready returning high: a read issues in the same cycle, so there is no throughput bubble beyond the buffer drain.

## Test plan
- base=0x0010, tiles=1, MUL_SIZE=4, ready=1 → rd_en cycles 1–4 at addr 0x10–0x13; wr_valid cycles 3–6 with rows 0x10–0x13; tile_done and done in cycle 7; busy cycles 1–6.
- Same command, ready low in cycles 4–8 → exactly 4 rows delivered in order, no duplicates; rd_en low while 2 rows are held; wr_data stable while stalled.
- tiles=0 → done pulses in cycle 1; no rd_en, no wr_valid, busy stays 0.
- base=0xFFFE, tiles=1, MUL_SIZE=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; rows arrive in that order.
- tiles=3 with random ready → 12 rows in order; tile_done pulses after rows 3, 7, 11; a start_i pulse mid-transfer is ignored.
- rst_i low during cycle 4 of a transfer → all outputs 0 immediately (asynchronous); after release, a new start completes normally with no stale rows.

Source files
------------

// File: rtl/tpu_package.sv
// tpu_package: shared systolic array sizing
package tpu_package;
  localparam int MUL_SIZE = 4;
endpackage

// File: rtl/weight_fetch_unit.sv
// weight_fetch_unit: streams weight tiles from memory into the weight FIFO through a 2-entry skid buffer
module weight_fetch_unit #(
  parameter int MUL_SIZE = tpu_package::MUL_SIZE,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int TILE_W   = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [TILE_W-1:0]          num_tiles_i,
  output logic                       weight_mem_rd_en_o,
  output logic [ADDR_W-1:0]          weight_mem_addr_o,
  input  logic [MUL_SIZE*DATA_W-1:0] weight_mem_data_i,
  output logic                       weight_fifo_wr_valid_o,
  input  logic                       weight_fifo_wr_ready_i,
  output logic [MUL_SIZE*DATA_W-1:0] weight_fifo_wr_data_o,
  output logic                       busy_o,
  output logic                       tile_done_o,
  output logic                       done_o
);
  localparam int W  = MUL_SIZE * DATA_W;
  localparam int RW = MUL_SIZE > 1 ? $clog2(MUL_SIZE) : 1;
  localparam int CW = TILE_W + RW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     rd_left;
  logic [TILE_W-1:0] num_tiles, tile_cntr;
  logic [RW-1:0]     row_cntr;
  logic              infl, pop, push, rd_en;
  logic [1:0]        occ;
  logic [W-1:0]      b0, b1;
  assign pop  = weight_fifo_wr_valid_o & weight_fifo_wr_ready_i;
  assign push = infl;
  // a slot freed by this cycle's pop may be refilled at once, so ready feeds rd_en directly
  assign rd_en = (state == FETCH) && (({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, pop}));
  assign weight_mem_rd_en_o     = rd_en;
  assign weight_mem_addr_o      = addr;
  assign weight_fifo_wr_valid_o = occ != 2'd0;
  assign weight_fifo_wr_data_o  = b0;
  assign busy_o                 = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      addr        <= '0;
      rd_left     <= '0;
      num_tiles   <= '0;
      tile_cntr   <= '0;
      row_cntr    <= '0;
      infl        <= 1'b0;
      occ         <= 2'd0;
      b0          <= '0;
      b1          <= '0;
      tile_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      tile_done_o <= 1'b0;
      done_o      <= 1'b0;
      infl        <= rd_en;
      if (rd_en) begin
        addr    <= addr + ADDR_W'(1);
        rd_left <= rd_left - CW'(1);
      end
      if (push && pop) begin
        if (occ == 2'd2) begin
          b0 <= b1;
          b1 <= weight_mem_data_i;
        end else begin
          b0 <= weight_mem_data_i;
        end
      end else if (pop) begin
        b0  <= b1;
        occ <= occ - 2'd1;
      end else if (push) begin
        if (occ == 2'd0) b0 <= weight_mem_data_i;
        else b1 <= weight_mem_data_i;
        occ <= occ + 2'd1;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            if (num_tiles_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state     <= FETCH;
              addr      <= base_addr_i;
              rd_left   <= CW'(num_tiles_i) * CW'(MUL_SIZE);
              num_tiles <= num_tiles_i;
              tile_cntr <= '0;
              row_cntr  <= '0;
            end
          end
        end
        FETCH: if (rd_en && rd_left == CW'(1)) state <= DRAIN;
        default: ;
      endcase
      if (pop && state != IDLE) begin
        if (row_cntr == RW'(MUL_SIZE - 1)) begin
          row_cntr    <= '0;
          tile_cntr   <= tile_cntr + TILE_W'(1);
          tile_done_o <= 1'b1;
          if (tile_cntr == num_tiles - TILE_W'(1)) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end else begin
          row_cntr <= row_cntr + RW'(1);
        end
      end
    end
  end
  overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_i) !(push && !pop && occ == 2'd2));
endmodule
